mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencer and arbiter for the core's single memory port, shared between instruction fetch (IF) and the memory stage (DM). It accepts level-held requests from both clients, issues one bus transaction at a time, and returns a one-cycle `valid` pulse with read data to the owning client. That pulse is what the memory stage consumes as its `mem_valid` / `mem_in` pair. One outstanding transaction; fixed or round-robin priority selected at compile time.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; write mask is `DW/8` bits

- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_req`  in  1  fetch request, held until `if_valid` or withdrawn
- `if_addr`  in  AW  fetch address (read only)
- `if_valid`  out  1  one-cycle fetch completion
- `if_rdata`  out  DW  fetch data, meaningful only with `if_valid`
- `dm_req`  in  1  data request, held until `dm_valid` or withdrawn
- `dm_addr`  in  AW  data address
- `dm_we`  in  1  1 = write, 0 = read
- `dm_wdata`  in  DW  write data
- `dm_wmask`  in  DW/8  byte enables for writes
- `dm_valid`  out  1  one-cycle data completion (reads and writes)
- `dm_rdata`  out  DW  read data, meaningful only with `dm_valid`
- `mem_req`  out  1  bus request, held until `mem_ack`
- `mem_addr`, `mem_we`, `mem_wdata`, `mem_wmask`  out  AW/1/DW/DW8  registered request fields, stable while `mem_req`
- `mem_ack`  in  1  bus accepted request this cycle
- `mem_rvalid`  in  1  bus response (read data or write done)
- `mem_rdata`  in  DW  bus read data

## Operation
- FSM states: IDLE, ISSUE, WAIT. Owner register `own` (IF/DM).
- IDLE:
  - If any `*_req` is high, select a winner, latch its address and write fields into the `mem_*` registers, set `own`, and go to ISSUE.
  - Fetch requests latch `mem_we=0` and `mem_wmask=0`.
- ISSUE: `mem_req=1`.
  - `mem_ack & mem_rvalid` → complete, go to IDLE.
  - `mem_ack` alone → WAIT.
  - Otherwise hold ISSUE.
- WAIT: `mem_rvalid` → complete, go to IDLE.
- Complete: pulse the owner's `valid` in the same cycle as `mem_rvalid`, combinationally. `*_rdata` is `mem_rdata` passed through to both clients.
- Withdrawal: if the owner's `*_req` is low in the completion cycle, the response is discarded (no `valid` pulse). The bus transaction itself is never aborted, and a write already issued still lands. This is used by fetch flush.
- `mem_rvalid` in IDLE, or in ISSUE without `mem_ack`, is ignored.
- Priority (default, macro off): DM always wins when both request. Fetch cannot starve, because the pipeline stalls on DM.
- Request fields change only in IDLE. Client changes to address or data during ISSUE/WAIT have no effect.

## Timing
- Reset values: state IDLE, `mem_req=0`, `mem_addr=0`, `mem_we=0`, `mem_wdata=0`, `mem_wmask=0`, `own=IF`, round-robin pointer = DM-first, `if_valid=dm_valid=0`.
- Minimum latency: request seen in IDLE at cycle N; `mem_req` high at N+1; with `ack` and `rvalid` both at N+1, `valid` pulses at N+1.
- Same-cycle `ack` + `rvalid` gives 2-cycle occupancy per transaction (IDLE plus ISSUE), so back-to-back throughput is one transaction per 2 cycles minimum.
- A client that re-asserts or holds `req` after its `valid` is treated as a new request, sampled at the next IDLE cycle.
- Reset asserted mid-transaction: asynchronous return to IDLE with `mem_req` dropped immediately. Late `mem_rvalid` after reset falls in IDLE and is ignored.

## Configuration
- `MEM_ARB_RR_EN` defined: when both clients request in IDLE, the winner alternates.
  - A one-bit pointer flips to the other client after each grant made while both were requesting.
  - A single requester always wins and does not flip the pointer.
- Undefined: fixed DM-over-IF priority; no pointer register.

## Test plan
- Single DM read, `addr=0x100`, `ack` and `rvalid` in the first ISSUE cycle with `rdata=0xDEADBEEF` → `mem_req` high one cycle; `dm_valid` one cycle with `dm_rdata=0xDEADBEEF`; `if_valid` stays 0.
- DM write, `wdata=0x12345678`, `wmask=0x3`, `ack` delayed 3 cycles, `rvalid` 2 cycles after `ack` → `mem_*` fields stable throughout; `mem_we=1`; a single `dm_valid` pulse.
- IF and DM requesting together, macro off, 3 transactions → DM granted each time, IF only after `dm_req` drops.
  - With `MEM_ARB_RR_EN` defined: grants go DM, IF, DM.
- IF request withdrawn while in WAIT, then `rvalid` → no `if_valid` pulse; FSM returns to IDLE and the next request issues normally.
- `rst` pulsed while in WAIT with `mem_req` active, followed by a stray `rvalid` → all outputs at reset values; no `valid` pulses.
- Stray `mem_rvalid` in IDLE and in ISSUE without `ack` → ignored, no state change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single memory port arbiter/sequencer shared by instruction fetch and data memory stage.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed DM-over-IF priority.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_valid,
  output logic [DW-1:0]   if_rdata,
  input  logic            dm_req,
  input  logic [AW-1:0]   dm_addr,
  input  logic            dm_we,
  input  logic [DW-1:0]   dm_wdata,
  input  logic [DW/8-1:0] dm_wmask,
  output logic            dm_valid,
  output logic [DW-1:0]   dm_rdata,
  output logic            mem_req,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_ack,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  logic [1:0]      state_q, state_d;
  logic            own_q, own_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            we_q, we_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic            grant_dm;
  logic            complete;

`ifdef MEM_ARB_RR_EN
  // rr_q names the client preferred on the next contested grant (1 = DM)
  logic rr_q, rr_d;

  always_comb begin
    grant_dm = dm_req;
    rr_d     = rr_q;
    if (if_req && dm_req) begin
      grant_dm = rr_q;
      if (state_q == S_IDLE) rr_d = ~rr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_q <= 1'b1;
    else     rr_q <= rr_d;
  end
`else
  assign grant_dm = dm_req;
`endif

  always_comb begin
    state_d  = state_q;
    own_d    = own_q;
    addr_d   = addr_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (if_req || dm_req) begin
          state_d = S_ISSUE;
          if (grant_dm) begin
            own_d   = OWN_DM;
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
            wmask_d = dm_wmask;
          end else begin
            own_d   = OWN_IF;
            addr_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      S_ISSUE: begin
        if (mem_ack) begin
          if (mem_rvalid) begin
            complete = 1'b1;
            state_d  = S_IDLE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          complete = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      own_q   <= OWN_IF;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      own_q   <= own_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  // A withdrawn request swallows its response; the bus side still completes
  assign if_valid  = complete && (own_q == OWN_IF) && if_req;
  assign dm_valid  = complete && (own_q == OWN_DM) && dm_req;
  assign if_rdata  = mem_rdata;
  assign dm_rdata  = mem_rdata;

  assign mem_req   = (state_q == S_ISSUE);
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule
